// File: rtl/pulse_period_checker.sv
// pulse_period_checker: measures rising-edge intervals of a pulse train against an expected period.
module pulse_period_checker #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 4,
  parameter int LOCK_N     = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pulse,
  output logic             pulse_edge,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout,
  output logic [7:0]       err_count
);
  localparam int GW = $clog2(LOCK_N + 1);
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE, LOCKED} state_t;
  state_t state, state_n;
  logic p_q, rise, hit, tmo, pv_n, err_n, to_n;
  logic [CNT_W-1:0] ctr, ctr_n, period_n;
  logic [GW-1:0] good_cnt, good_n;
  always_comb begin
    rise = pulse & ~p_q;
    hit = ctr == CNT_W'(EXP_PERIOD);
    tmo = ~rise & (ctr == CNT_W'(TIMEOUT));
    state_n = state;
    good_n = good_cnt;
    period_n = period;
    pv_n = 1'b0;
    err_n = 1'b0;
    to_n = 1'b0;
    ctr_n = rise ? CNT_W'(1) : ctr + {{(CNT_W-1){1'b0}}, ~&ctr};
    if (!enable) begin
      state_n = IDLE;
      ctr_n = '0;
      good_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = WAIT_FIRST;
          ctr_n = '0;
          good_n = '0;
        end
        WAIT_FIRST: state_n = rise ? MEASURE : WAIT_FIRST;
        default: begin
          if (rise) begin
            period_n = ctr;
            pv_n = 1'b1;
            if (!hit) begin
              err_n = 1'b1;
              good_n = '0;
              state_n = MEASURE;
            end else if (state == MEASURE) begin
              good_n = good_cnt + 1'b1;
              state_n = (good_n == GW'(LOCK_N)) ? LOCKED : MEASURE;
            end
          end else if (tmo) begin
            err_n = 1'b1;
            to_n = 1'b1;
            good_n = '0;
            state_n = WAIT_FIRST;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      p_q <= 1'b0;
      ctr <= '0;
      good_cnt <= '0;
      period <= '0;
      period_valid <= 1'b0;
      err <= 1'b0;
      timeout <= 1'b0;
      locked <= 1'b0;
      pulse_edge <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_n;
      p_q <= pulse;
      ctr <= ctr_n;
      good_cnt <= good_n;
      period <= period_n;
      period_valid <= pv_n;
      err <= err_n;
      timeout <= to_n;
      locked <= state_n == LOCKED;
      pulse_edge <= rise & enable & (state != IDLE);
      if (err_n && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_pulse_period_checker.sv
// tb_pulse_period_checker: scoreboard bench comparing every cycle against an interval-based model.
module tb_pulse_period_checker;
  localparam int EXP = 4, LOCKN = 3, TO = 16;
  logic clk = 0, reset = 1, enable = 0, pulse = 0;
  logic pulse_edge, period_valid, locked, err, timeout;
  logic [7:0] period, err_count;
  int checks = 0, failures = 0, nedge = 0;
  int cyc = 0, ms = 0, mlast = 0, mgood = 0, mper = 0, mec = 0;
  logic mprev = 0;
  typedef struct {
    int e, per, pv, lk, er, to, ec;
  } exp_t;
  exp_t sb[$];
  pulse_period_checker #(.CNT_W(8), .EXP_PERIOD(EXP), .LOCK_N(LOCKN), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pulse(pulse),
    .pulse_edge(pulse_edge), .period(period), .period_valid(period_valid),
    .locked(locked), .err(err), .timeout(timeout), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, act, exp, cyc);
    end
  endtask
  // Model tracks the cycle of the last accepted rise; interval = cycles elapsed since it.
  task automatic step(input logic r, input logic e, input logic p);
    exp_t x, y;
    int iv;
    logic rise;
    reset = r;
    enable = e;
    pulse = p;
    x = '{default: 0};
    if (r) begin
      ms = 0; mprev = 0; mgood = 0; mper = 0; mec = 0;
    end else begin
      rise = p && !mprev;
      mprev = p;
      x.e = (rise && e && ms != 0) ? 1 : 0;
      iv = cyc - mlast;
      if (!e) begin
        ms = 0; mgood = 0;
      end else if (ms == 0) ms = 1;
      else if (ms == 1) begin
        if (rise) begin mlast = cyc; ms = 2; end
      end else if (rise) begin
        mper = iv > 255 ? 255 : iv;
        x.pv = 1;
        mlast = cyc;
        if (iv != EXP) begin
          x.er = 1; mgood = 0; ms = 2;
        end else if (ms == 2) begin
          mgood = mgood + 1;
          if (mgood == LOCKN) ms = 3;
        end
      end else if (iv == TO) begin
        x.er = 1; x.to = 1; mgood = 0; ms = 1;
      end
      if (x.er == 1 && mec < 255) mec++;
    end
    x.per = mper;
    x.lk = ms == 3 ? 1 : 0;
    x.ec = mec;
    sb.push_back(x);
    cyc++;
    @(posedge clk);
    #1;
    y = sb.pop_front();
    chk("edge", int'(pulse_edge), y.e);
    chk("period", int'(period), y.per);
    chk("period_valid", int'(period_valid), y.pv);
    chk("locked", int'(locked), y.lk);
    chk("err", int'(err), y.er);
    chk("timeout", int'(timeout), y.to);
    chk("err_count", int'(err_count), y.ec);
    if (pulse_edge) nedge++;
  endtask
  task automatic pulses(input int n, input int per, input logic e);
    repeat (n) begin
      step(0, e, 1);
      repeat (per - 1) step(0, e, 0);
    end
  endtask
  initial begin
    step(1, 0, 0);
    step(1, 0, 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_count", int'(err_count), 0);
    step(0, 1, 0);
    step(0, 1, 1);
    chk("first_rise_pv", int'(period_valid), 0);
    repeat (3) step(0, 1, 0);
    pulses(3, 4, 1);
    chk("lock_clean", int'(locked), 1);
    chk("lock_period", int'(period), 4);
    chk("lock_no_err", int'(err_count), 0);
    pulses(1, 5, 1);
    step(0, 1, 1);
    chk("bad_period", int'(period), 5);
    chk("bad_err", int'(err), 1);
    chk("bad_err_count", int'(err_count), 1);
    step(0, 1, 0);
    chk("bad_unlock", int'(locked), 0);
    repeat (2) step(0, 1, 0);
    pulses(3, 4, 1);
    chk("relock", int'(locked), 1);
    repeat (12) step(0, 1, 0);
    chk("pre_timeout", int'(timeout), 0);
    step(0, 1, 0);
    chk("timeout", int'(timeout), 1);
    chk("timeout_err", int'(err), 1);
    chk("timeout_unlock", int'(locked), 0);
    chk("timeout_err_count", int'(err_count), 2);
    step(0, 1, 1);
    chk("after_to_pv", int'(period_valid), 0);
    repeat (3) step(0, 1, 0);
    pulses(3, 4, 1);
    chk("relock2", int'(locked), 1);
    step(1, 1, 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_err_count", int'(err_count), 0);
    chk("midrst_period", int'(period), 0);
    step(0, 1, 0);
    pulses(3, 4, 1);
    chk("rst_3rises", int'(locked), 0);
    pulses(1, 4, 1);
    chk("rst_4rises", int'(locked), 1);
    pulses(300, 3, 1);
    chk("saturate", int'(err_count), 255);
    nedge = 0;
    pulses(2, 4, 0);
    chk("dis_edges", nedge, 0);
    chk("dis_hold", int'(err_count), 255);
    step(0, 1, 0);
    step(0, 1, 1);
    chk("reen_edge", int'(pulse_edge), 1);
    chk("reen_pv", int'(period_valid), 0);
    repeat (3) step(0, 1, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    nedge = 0;
    repeat (16) step(0, 1, 1);
    chk("stuck_pre_to", int'(timeout), 0);
    step(0, 1, 1);
    chk("stuck_timeout", int'(timeout), 1);
    repeat (4) step(0, 1, 1);
    chk("stuck_edges", nedge, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
